// File: rtl/conv_loader_pkg.sv
// Shared constants and FSM state type for the convolution operand loader.
package conv_pkg;
    localparam int DATA_W  = 8;
    localparam int IMG_N   = 4;
    localparam int KER_N   = 3;
    localparam int IMG_CNT = 16;
    localparam int KER_CNT = 9;
    localparam int CNT_W   = 5;

    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_CNT - 1);
    localparam logic [CNT_W-1:0] KER_LAST = CNT_W'(KER_CNT - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FIRE   = 2'd2,
        WAIT   = 2'd3
    } state_t;
endpackage

// File: rtl/conv_loader_if.sv
// Byte stream, array handshake and operand bus between source, loader and systolic array.
interface conv_loader_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              start;
    logic              done;
    logic              busy;
    logic [DATA_W-1:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [DATA_W-1:0] a31, a32, a33, a34, a41, a42, a43, a44;
    logic [DATA_W-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;

    modport master (
        output in_data, in_valid, done,
        input  in_ready, start, busy,
        input  a11, a12, a13, a14, a21, a22, a23, a24,
        input  a31, a32, a33, a34, a41, a42, a43, a44,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33
    );

    modport slave (
        input  in_data, in_valid, done,
        output in_ready, start, busy,
        output a11, a12, a13, a14, a21, a22, a23, a24,
        output a31, a32, a33, a34, a41, a42, a43, a44,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33
    );
endinterface

// File: rtl/conv_loader.sv
// Loads a 4x4 image and 3x3 kernel from a byte stream, then fires the systolic array.
// Optional CONV_LOADER_KEEP_KERNEL_EN reuses the stored kernel after the first full frame.
module conv_loader #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int IMG_N  = conv_pkg::IMG_N,
    parameter int KER_N  = conv_pkg::KER_N
) (
    input  logic         clk,
    input  logic         rst,
    conv_loader_if.slave bus
);
    import conv_pkg::*;

    localparam int A_IDX_W = $clog2(IMG_N * IMG_N);
    localparam int B_IDX_W = $clog2(KER_N * KER_N);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_start;
    logic               r_busy;
    logic [DATA_W-1:0]  r_a [IMG_N*IMG_N];
    logic [DATA_W-1:0]  r_b [KER_N*KER_N];
    logic               w_accept;
    logic               w_skip_b;

    // in_ready is registered so it stays low throughout reset and rises one edge later
    assign w_accept = bus.in_valid & r_ready;

`ifdef CONV_LOADER_KEEP_KERNEL_EN
    logic r_kvalid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_kvalid <= 1'b0;
        else if (w_accept && r_state == LOAD_B && r_cnt == KER_LAST)
            r_kvalid <= 1'b1;
    end
    assign w_skip_b = r_kvalid;
`else
    assign w_skip_b = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD_A;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < IMG_N*IMG_N; i++) r_a[i] <= '0;
            for (int i = 0; i < KER_N*KER_N; i++) r_b[i] <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_a[r_cnt[A_IDX_W-1:0]] <= bus.in_data;
                        if (r_cnt == IMG_LAST) begin
                            r_cnt <= '0;
                            if (w_skip_b) begin
                                r_state <= FIRE;
                                r_ready <= 1'b0;
                                r_start <= 1'b1;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= LOAD_B;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        r_b[r_cnt[B_IDX_W-1:0]] <= bus.in_data;
                        if (r_cnt == KER_LAST) begin
                            r_cnt   <= '0;
                            r_state <= FIRE;
                            r_ready <= 1'b0;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                // done is deliberately not looked at here so WAIT always lasts at least a cycle
                FIRE: r_state <= WAIT;
                WAIT: begin
                    if (bus.done) begin
                        r_state <= LOAD_A;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.start    = r_start;
    assign bus.busy     = r_busy;

    assign bus.a11 = r_a[0];   assign bus.a12 = r_a[1];
    assign bus.a13 = r_a[2];   assign bus.a14 = r_a[3];
    assign bus.a21 = r_a[4];   assign bus.a22 = r_a[5];
    assign bus.a23 = r_a[6];   assign bus.a24 = r_a[7];
    assign bus.a31 = r_a[8];   assign bus.a32 = r_a[9];
    assign bus.a33 = r_a[10];  assign bus.a34 = r_a[11];
    assign bus.a41 = r_a[12];  assign bus.a42 = r_a[13];
    assign bus.a43 = r_a[14];  assign bus.a44 = r_a[15];

    assign bus.b11 = r_b[0];   assign bus.b12 = r_b[1];
    assign bus.b13 = r_b[2];   assign bus.b21 = r_b[3];
    assign bus.b22 = r_b[4];   assign bus.b23 = r_b[5];
    assign bus.b31 = r_b[6];   assign bus.b32 = r_b[7];
    assign bus.b33 = r_b[8];
endmodule

// File: doc/conv_loader.md
CONV_LOADER -- requirements
Module: conv_loader

Interface
REQ-001 Parameters: DATA_W, default 8, pixel and weight width; IMG_N, default 4, image edge; KER_N, default 3, kernel edge.
REQ-002 clk  input  1  rising-edge clock, the block's only clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  DATA_W  serial byte stream: 16 image bytes, then 9 kernel bytes, each group row-major.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  loader accepts in_data this cycle.
REQ-007 a11..a44  output  DATA_W each  registered 4x4 image for the downstream 3x3 systolic array.
REQ-008 b11..b33  output  DATA_W each  registered 3x3 kernel for the downstream array.
REQ-009 start  output  1  one-cycle pulse telling the array that operands are stable.
REQ-010 done  input  1  array finished; the 2x2 result has been consumed.
REQ-011 busy  output  1  high from the start pulse until done is accepted.

Function
REQ-012 The block SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-013 The FSM SHALL have states LOAD_A, LOAD_B, FIRE and WAIT; it enters LOAD_A on reset.
REQ-014 In LOAD_A: in_ready=1; accepted byte k (0..15) is written to a(k/4+1)(k%4+1); after byte 15 the FSM goes to LOAD_B.
REQ-015 In LOAD_B: in_ready=1; accepted byte k (0..8) is written to b(k/3+1)(k%3+1); after byte 8 the FSM goes to FIRE.
REQ-016 In FIRE: start=1 for exactly one cycle, then the FSM goes to WAIT; start SHALL rise on the cycle after the 25th accepted byte.
REQ-017 In WAIT: in_ready=0, busy=1; when done=1 the FSM goes to LOAD_A on the next edge and the element counter clears.
REQ-018 The a and b registers SHALL change only on accepted bytes; they SHALL hold their values through FIRE and WAIT.
REQ-019 A 5-bit element counter SHALL count 0..15 in LOAD_A and 0..8 in LOAD_B, then wrap to 0 on each state change.
REQ-020 done in LOAD_A, LOAD_B or FIRE SHALL be ignored; done and start in the same cycle SHALL NOT shorten WAIT.
REQ-021 in_valid in FIRE or WAIT SHALL be ignored: no write and no counter change.
REQ-022 Gaps in in_valid SHALL stall loading without losing position.

Reset
REQ-023 While rst=0: state=LOAD_A, counter=0, all a and b outputs=0, start=0, busy=0, in_ready=0.
REQ-024 in_ready SHALL go to 1 on the first edge after rst is released.
REQ-025 Reset in any state SHALL abort the frame; no start pulse follows the abort.

Configuration
REQ-026 Macro CONV_LOADER_KEEP_KERNEL_EN: when defined, LOAD_B SHALL be skipped after the first completed frame since reset, so each frame is 16 bytes and the stored kernel is reused.
REQ-027 When CONV_LOADER_KEEP_KERNEL_EN is defined, an internal kernel-valid flag SHALL be cleared by reset and set when LOAD_B completes.
REQ-028 When CONV_LOADER_KEEP_KERNEL_EN is undefined, every frame SHALL be 25 bytes.

Structure
REQ-029 Package conv_pkg SHALL hold DATA_W, IMG_N, KER_N, the state enum for LOAD_A/LOAD_B/FIRE/WAIT, and the constants IMG_CNT=16 and KER_CNT=9.
REQ-030 conv_loader SHALL be a single flat module with no sub-module; the register banks are written by decoded counter index.

Verification
REQ-031 Scenario 1, basic frame: bytes 1..16 then 1..9 with in_valid held high -> a11=1, a44=16, b11=1, b33=9, start high in cycle 26 only.
REQ-032 Scenario 2, gapped input: in_valid toggled 1/0 over the same stream -> identical a/b values; start one cycle after the 25th accepted byte.
REQ-033 Scenario 3, backpressure: in_valid=1 with data 0xFF during WAIT for 10 cycles -> in_ready=0 and outputs unchanged; done=1 -> in_ready=1 next cycle.
REQ-034 Scenario 4, reset mid-load: rst=0 after 7 image bytes -> all outputs 0; the next 25 bytes load from a11 with no stray start.
REQ-035 Scenario 5, spurious done: done=1 during LOAD_A -> no state change and loading continues.
REQ-036 Scenario 6, with CONV_LOADER_KEEP_KERNEL_EN: second frame of 16 bytes (0x10..0x1F) -> start after byte 16 and b values retained from frame 1.
